// File: rtl/npc_seq.sv
`default_nettype none
// ============================================================================
// Module   : npc_seq
// Brief    : Registered next-PC / fetch-address generator with redirect
//            arbitration and an optional direct-mapped BTB (NPC_BTB_EN).
// Revision : 1.0 - initial release
// ============================================================================
module npc_seq #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h1C00_0000,
    parameter int               BTB_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_sig,
    input  logic [WIDTH-1:0] eentry,
    input  logic             ertn,
    input  logic [WIDTH-1:0] sepc,
    input  logic             ex_redirect,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             stall_signal,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic [WIDTH-1:0] upd_target,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             req_inst_success,
    output logic             pred_taken,
    output logic             fetch_discard,
    output logic [WIDTH-1:0] pc
);

    localparam logic [WIDTH-1:0] C_STEP = WIDTH'(4);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        RUN      = 2'd1,
        PEND     = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_pc;
    logic             r_inst_req;

    logic             w_redirect;
    logic [WIDTH-1:0] w_tgt;
    logic             w_acc;
    logic             w_hit;
    logic [WIDTH-1:0] w_pred_tgt;
    logic [WIDTH-1:0] w_seq_pc;

    assign w_redirect = exc_sig | ertn | ex_redirect;
    assign w_tgt      = exc_sig ? eentry : (ertn ? sepc : ex_target);
    assign w_acc      = r_inst_req & req_inst_success;

`ifdef NPC_BTB_EN
    localparam int IW = $clog2(BTB_DEPTH);
    localparam int TW = WIDTH - IW - 2;

    logic [BTB_DEPTH-1:0] r_btb_valid;
    logic [TW-1:0]        r_btb_tag [BTB_DEPTH];
    logic [WIDTH-1:0]     r_btb_tgt [BTB_DEPTH];
    logic [IW-1:0]        w_rd_idx;
    logic [IW-1:0]        w_wr_idx;
    logic                 w_unused_upd_lo;

    assign w_rd_idx        = r_pc[IW+1:2];
    assign w_wr_idx        = upd_pc[IW+1:2];
    assign w_unused_upd_lo = ^upd_pc[1:0];

    // Lookup reads the registered arrays, so a same-cycle write is not seen.
    assign w_hit      = r_btb_valid[w_rd_idx] && (r_btb_tag[w_rd_idx] == r_pc[WIDTH-1:IW+2]);
    assign w_pred_tgt = r_btb_tgt[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btb_valid <= '0;
        end else if (upd_valid) begin
            r_btb_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag and target storage needs no reset; the valid bit gates every use.
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            r_btb_tag[w_wr_idx] <= upd_pc[WIDTH-1:IW+2];
            r_btb_tgt[w_wr_idx] <= upd_target;
        end
    end
`else
    logic w_unused_upd;

    assign w_unused_upd = ^{upd_valid, upd_pc, upd_target};
    assign w_hit        = 1'b0;
    assign w_pred_tgt   = '0;
`endif

    assign w_seq_pc = w_hit ? w_pred_tgt : (r_pc + C_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RST_WAIT;
            r_pc       <= RESET_PC;
            r_pend_pc  <= '0;
            r_inst_req <= 1'b0;
        end else begin
            case (r_state)
                RST_WAIT: begin
                    r_state    <= RUN;
                    r_inst_req <= 1'b1;
                    if (w_redirect) begin
                        r_pc <= w_tgt;
                    end
                end
                RUN: begin
                    if (w_redirect) begin
                        // An outstanding unaccepted request must keep its address.
                        if (w_acc || !r_inst_req) begin
                            r_pc <= w_tgt;
                        end else begin
                            r_pend_pc <= w_tgt;
                            r_state   <= PEND;
                        end
                    end else if (!stall_signal && w_acc) begin
                        r_pc <= w_seq_pc;
                    end
                end
                PEND: begin
                    if (w_redirect) begin
                        r_pend_pc <= w_tgt;
                    end
                    if (w_acc) begin
                        r_pc    <= w_redirect ? w_tgt : r_pend_pc;
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state    <= RST_WAIT;
                    r_inst_req <= 1'b0;
                end
            endcase
        end
    end

    assign inst_req      = r_inst_req;
    assign inst_addr     = r_pc;
    assign pc            = r_pc;
    assign pred_taken    = w_acc & w_hit;
    assign fetch_discard = w_acc & (r_state == PEND);

endmodule
`default_nettype wire
